// File: rtl/mult_share_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mult_share_pkg
//  Description : Shared types and constants for the shared-multiplier
//                arbiter: FSM state encoding, default parameter values and
//                a constant-evaluable clog2 used to size requester IDs.
//  Revision    : 1.0  initial release
// ============================================================================
package mult_share_pkg;

    localparam int DEF_SIZE = 8;
    localparam int DEF_NREQ = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Minimum of 1 so a requester ID is never a zero-width vector.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mult_share_arb_if.sv
`default_nettype none
// ============================================================================
//  Module      : mult_share_arb_if
//  Description : Request/response bus of the shared multiplier.
//                master : requesters + product consumer
//                slave  : the arbiter (mult_share_arb)
//  Signals     : req_valid/req_ready (NREQ), req_a/req_b (NREQ*SIZE packed),
//                rsp_valid/rsp_ready, rsp_q (2*SIZE), rsp_id (ID_W), busy
//  Revision    : 1.0  initial release
// ============================================================================
interface mult_share_arb_if #(
    parameter int SIZE = mult_share_pkg::DEF_SIZE,
    parameter int NREQ = mult_share_pkg::DEF_NREQ
);
    import mult_share_pkg::*;

    localparam int ID_W = clog2(NREQ);

    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*SIZE-1:0] req_a;
    logic [NREQ*SIZE-1:0] req_b;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [2*SIZE-1:0]    rsp_q;
    logic [ID_W-1:0]      rsp_id;
    logic                 busy;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_q, rsp_id, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_q, rsp_id, busy
    );

endinterface
`default_nettype wire

// File: rtl/mult_share_arb_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : mult_rr_pick
//  Description : Combinational round-robin picker. Scans req_valid starting
//                at rr_ptr and wrapping modulo NREQ; the first set bit wins.
//  Ports       : req_valid (in, NREQ)  rr_ptr (in, ID_W)
//                grant (out, NREQ one-hot) any_valid (out) winner (out, ID_W)
//  Revision    : 1.0  initial release
// ============================================================================
module mult_rr_pick #(
    parameter int NREQ = mult_share_pkg::DEF_NREQ,
    parameter int ID_W = mult_share_pkg::clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [ID_W-1:0] rr_ptr,
    output logic [NREQ-1:0] grant,
    output logic            any_valid,
    output logic [ID_W-1:0] winner
);

    // One extra bit so rr_ptr + offset cannot overflow before the modulo.
    localparam logic [ID_W:0] C_NREQ = (ID_W+1)'(NREQ);

    logic [ID_W:0]   w_sum;
    logic [ID_W-1:0] w_idx;

    always_comb begin
        grant     = '0;
        any_valid = 1'b0;
        winner    = '0;
        w_sum     = '0;
        w_idx     = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (w_sum >= C_NREQ) begin
                w_sum = w_sum - C_NREQ;
            end
            w_idx = w_sum[ID_W-1:0];
            if (!any_valid && req_valid[w_idx]) begin
                any_valid    = 1'b1;
                winner       = w_idx;
                grant[w_idx] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mult_share_arb.sv
`default_nettype none
// ============================================================================
//  Module      : mult_share_arb
//  Description : Shares one SIZE x SIZE unsigned multiplier among NREQ
//                requesters. Round-robin grant in IDLE, one multiply cycle,
//                then the tagged product is held until the consumer accepts.
//  Ports       : clk   (in)  rising-edge clock
//                rst_n (in)  synchronous active-low reset
//                bus   (mult_share_arb_if.slave) request/response bus
//  Revision    : 1.0  initial release
// ============================================================================
module mult_share_arb #(
    parameter int SIZE = mult_share_pkg::DEF_SIZE,
    parameter int NREQ = mult_share_pkg::DEF_NREQ
) (
    input  logic             clk,
    input  logic             rst_n,
    mult_share_arb_if.slave  bus
);
    import mult_share_pkg::*;

    localparam int ID_W = clog2(NREQ);
    localparam logic [ID_W-1:0] C_LAST_ID = ID_W'(NREQ - 1);

    state_t              r_state;
    logic [ID_W-1:0]     r_rr_ptr;
    logic [ID_W-1:0]     r_id;
    logic [SIZE-1:0]     r_op_a;
    logic [SIZE-1:0]     r_op_b;
    logic [2*SIZE-1:0]   r_prod;
    logic                r_rsp_valid;
    logic                r_busy;

    logic [NREQ-1:0]     w_grant;
    logic                w_any;
    logic [ID_W-1:0]     w_winner;
    logic [ID_W-1:0]     w_next_ptr;

    mult_rr_pick #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_pick (
        .req_valid (bus.req_valid),
        .rr_ptr    (r_rr_ptr),
        .grant     (w_grant),
        .any_valid (w_any),
        .winner    (w_winner)
    );

    // Pointer moves past the winner, so a lone requester still wins next
    // time because the scan wraps all the way round.
    assign w_next_ptr = (w_winner == C_LAST_ID) ? '0 : (w_winner + ID_W'(1));

    // Gated with rst_n so no grant is offered in a reset cycle.
    assign bus.req_ready = (rst_n && (r_state == ST_IDLE)) ? w_grant : '0;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_q     = r_prod;
    assign bus.rsp_id    = r_id;
    assign bus.busy      = r_busy;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= '0;
            r_id        <= '0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_prod      <= '0;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_op_a   <= bus.req_a[w_winner*SIZE +: SIZE];
                        r_op_b   <= bus.req_b[w_winner*SIZE +: SIZE];
                        r_id     <= w_winner;
                        r_rr_ptr <= w_next_ptr;
                        r_state  <= ST_MUL;
                        r_busy   <= 1'b1;
                    end
                end
                ST_MUL: begin
                    // Widen both operands first so the product is never truncated.
                    r_prod      <= (2*SIZE)'(r_op_a) * (2*SIZE)'(r_op_b);
                    r_rsp_valid <= 1'b1;
                    r_state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mult_share_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult_share_arb
//  Description : Self-checking bench for mult_share_arb. A reference model
//                predicts grants and timing and queues expected products; a
//                monitor compares every presented response to the queue.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mult_share_arb;

    localparam int SIZE = 8;
    localparam int NREQ = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mult_share_arb_if #(.SIZE(SIZE), .NREQ(NREQ)) bus ();

    mult_share_arb #(.SIZE(SIZE), .NREQ(NREQ)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int id;
        int q;
    } exp_t;

    exp_t            exp_q[$];
    int              grant_log[$];
    int              errors = 0;
    int              checks = 0;
    int              m_ptr  = 0;
    int              m_age  = 0;   // 0 idle, 1 cycle after grant, >=2 responding
    logic [NREQ-1:0] m_last_grant = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // First valid requester scanning from ptr, modulo NREQ; -1 if none.
    function automatic int pick(input logic [NREQ-1:0] v, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    // Reference model: grant prediction, timing and expected products.
    always @(negedge clk) begin
        int              w;
        logic [NREQ-1:0] exp_rdy;
        exp_t            e;
        if (!rst_n) begin
            check("ready_in_reset", 32'(bus.req_ready), 32'd0);
            m_ptr = 0;
            m_age = 0;
            m_last_grant = '0;
            exp_q.delete();
        end else begin
            check("busy", 32'(bus.busy), 32'(m_age != 0));
            check("rsp_valid", 32'(bus.rsp_valid), 32'(m_age >= 2));
            m_last_grant = '0;
            if (m_age == 0) begin
                w = pick(bus.req_valid, m_ptr);
                exp_rdy = (w < 0) ? '0 : (NREQ'(1) << w);
                check("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
                if (w >= 0) begin
                    e.id = w;
                    e.q  = int'(bus.req_a[w*SIZE +: SIZE]) * int'(bus.req_b[w*SIZE +: SIZE]);
                    exp_q.push_back(e);
                    grant_log.push_back(w);
                    m_ptr = (w + 1) % NREQ;
                    m_age = 1;
                    m_last_grant = exp_rdy;
                end
            end else begin
                check("req_ready_blocked", 32'(bus.req_ready), 32'd0);
                if (m_age == 1) m_age = 2;
                else if (bus.rsp_ready) m_age = 0;
            end
        end
    end

    // Monitor: every presented response must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && bus.rsp_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got id=%0d q=%0h expected none at %0t",
                         bus.rsp_id, bus.rsp_q, $time);
            end else begin
                check("rsp_q", 32'(bus.rsp_q), 32'(exp_q[0].q));
                check("rsp_id", 32'(bus.rsp_id), 32'(exp_q[0].id));
                if (bus.rsp_ready) void'(exp_q.pop_front());
            end
        end
    end

    // Advance one cycle; requesters granted last cycle drop their valid.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (m_last_grant[i]) bus.req_valid[i] = 1'b0;
        end
    endtask

    task automatic raise(input int i, input int a, input int b);
        bus.req_a[i*SIZE +: SIZE] = SIZE'(a);
        bus.req_b[i*SIZE +: SIZE] = SIZE'(b);
        bus.req_valid[i] = 1'b1;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int n = 0; n < 300 && !done; n++) begin
            tick();
            if (bus.req_valid == '0 && !bus.busy && exp_q.size() == 0) done = 1'b1;
        end
        check("drain_timeout", 32'(done), 32'd1);
    endtask

    task automatic wait_rsp();
        bit done;
        done = 1'b0;
        for (int n = 0; n < 50 && !done; n++) begin
            tick();
            if (bus.rsp_valid) done = 1'b1;
        end
        check("rsp_timeout", 32'(done), 32'd1);
    endtask

    initial begin
        int base;
        int fair_exp[5] = '{0, 1, 2, 3, 0};

        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b1;
        rst_n         = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        // Reset state
        check("reset_rsp_q", 32'(bus.rsp_q), 32'd0);
        check("reset_rsp_id", 32'(bus.rsp_id), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);

        // Single request from requester 2
        raise(2, 8'h0F, 8'h11);
        #1;
        check("single_ready", 32'(bus.req_ready), 32'b0100);
        wait_idle();

        // Width boundaries
        raise(0, 8'hFF, 8'hFF);
        wait_idle();
        raise(1, 8'h00, 8'hAB);
        wait_idle();

        // Fairness from a freshly reset pointer
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        base = grant_log.size();
        for (int i = 0; i < NREQ; i++) raise(i, i + 1, 8'h10);
        for (int n = 0; n < 15; n++) begin
            tick();
            for (int i = 0; i < NREQ; i++) begin
                if (!bus.req_valid[i]) raise(i, i + 1, 8'h10);
            end
        end
        check("fair_count", 32'(grant_log.size() - base >= 5), 32'd1);
        if (grant_log.size() - base >= 5) begin
            for (int k = 0; k < 5; k++) check("fair_order", 32'(grant_log[base + k]), 32'(fair_exp[k]));
        end
        wait_idle();

        // Backpressure: response held 5 cycles, pending requester blocked
        bus.rsp_ready = 1'b0;
        raise(3, 8'h12, 8'h34);
        wait_rsp();
        raise(0, 8'h03, 8'h05);
        for (int n = 0; n < 5; n++) begin
            tick();
            check("bp_valid", 32'(bus.rsp_valid), 32'd1);
            check("bp_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        tick();
        check("bp_release_valid", 32'(bus.rsp_valid), 32'd0);
        check("bp_next_grant", 32'(bus.req_ready), 32'b0001);
        wait_idle();

        // Reset during MUL aborts the operation
        raise(0, 8'h05, 8'h06);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        base = grant_log.size();
        raise(3, 8'h07, 8'h09);
        wait_idle();
        check("abort_regrant", 32'(grant_log.size() > base ? grant_log[base] : -1), 32'd3);

        // Late arrival in the response handshake cycle
        raise(0, 8'h21, 8'h02);
        wait_rsp();
        raise(1, 8'h0A, 8'h0B);
        check("late_not_yet", 32'(bus.req_ready), 32'd0);
        tick();
        check("late_granted", 32'(bus.req_ready), 32'b0010);
        wait_idle();

        // Randomised traffic with random backpressure
        for (int n = 0; n < 600; n++) begin
            tick();
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NREQ; i++) begin
                if (!bus.req_valid[i] && $urandom_range(0, 2) == 0)
                    raise(i, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
            end
        end
        bus.rsp_ready = 1'b1;
        wait_idle();
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
